// File: rtl/mult_seq_param_if.sv
// mult_seq_param_if: request/result bundle for the sequential multiplier.
// The master side issues start/abort and operands; the slave side (the
// multiplier) returns busy, the done pulse and the product.
interface mult_seq_param_if #(
   parameter int WIDTH = 16
);
   logic                 start;
   logic                 signed_mode;
   logic                 abort;
   logic [WIDTH-1:0]     mult1;
   logic [WIDTH-1:0]     mult2;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   produto;

   modport master (
      output start, signed_mode, abort, mult1, mult2,
      input  busy, done, produto
   );

   modport slave (
      input  start, signed_mode, abort, mult1, mult2,
      output busy, done, produto
   );
endinterface

// File: rtl/mult_seq_param.sv
// mult_seq_param: parametrised shift-add multiplier, one multiplier bit per
// cycle, with signed/unsigned mode, start/busy/done handshake and abort.
// Operands are reduced to magnitudes on capture; the sign is restored in FIX.
// Optional feature macro: MULT_EARLY_EXIT_EN -- leaves RUN as soon as the
// remaining multiplier bits are all zero and right-aligns the accumulator.
module mult_seq_param #(
   parameter int WIDTH = 16
) (
   input logic               clk,
   input logic               rst_n,
   mult_seq_param_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic                  load_s;
   logic                  step_s;
   logic                  finish_s;
   logic                  last_iter_s;

   // {upper WIDTH+1 accumulator bits, WIDTH multiplier bits}
   logic [2*WIDTH:0]      comb_r;
   logic [2*WIDTH:0]      comb_step_s;
   logic [WIDTH:0]        sum_s;
   logic [WIDTH-1:0]      mcand_r;
   logic                  neg_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [2*WIDTH-1:0]    prod_s;
   logic [2*WIDTH-1:0]    result_s;

   logic                  busy_r;
   logic                  done_r;
   logic [2*WIDTH-1:0]    produto_r;

`ifdef MULT_EARLY_EXIT_EN
   logic [WIDTH-1:0]      mrem_r;
   logic [CNT_W-1:0]      shamt_s;
`endif

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v,
                                               input logic sm);
      if (sm && v[WIDTH-1]) begin
         mag_f = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag_f = v;
      end
   endfunction

   // Last-iteration detection: fixed count, or remaining bits exhausted.
   always_comb begin
      last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_EXIT_EN
      if ((mrem_r >> 1) == {WIDTH{1'b0}}) begin
         last_iter_s = 1'b1;
      end else begin
         last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
      end
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath strobes; abort always wins.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      step_s      = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.abort) begin
               state_nxt_s = ST_IDLE;
            end else if (bus.start) begin
               load_s      = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_nxt_s = ST_IDLE;
            end else begin
               step_s = 1'b1;
               if (last_iter_s) begin
                  state_nxt_s = ST_FIX;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
         end
         ST_FIX: begin
            if (bus.abort) begin
               state_nxt_s = ST_IDLE;
            end else begin
               finish_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // One shift-add step: conditional add into the upper bits, then shift right.
   always_comb begin
      if (comb_r[0]) begin
         sum_s = comb_r[2*WIDTH:WIDTH] + {1'b0, mcand_r};
      end else begin
         sum_s = comb_r[2*WIDTH:WIDTH];
      end
      comb_step_s = {sum_s, comb_r[WIDTH-1:0]} >> 1;
   end

   // Product alignment and sign restoration for the FIX write.
   always_comb begin
`ifdef MULT_EARLY_EXIT_EN
      shamt_s = CNT_W'(WIDTH) - cnt_r;
      prod_s  = (2*WIDTH)'(comb_r >> shamt_s);
`else
      prod_s  = comb_r[2*WIDTH-1:0];
`endif
      if (neg_r) begin
         result_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
         result_s = prod_s;
      end
   end

   // Operand capture and iteration datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         comb_r  <= {(2*WIDTH+1){1'b0}};
         mcand_r <= {WIDTH{1'b0}};
         neg_r   <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
`ifdef MULT_EARLY_EXIT_EN
         mrem_r  <= {WIDTH{1'b0}};
`endif
      end else if (load_s) begin
         comb_r  <= {{(WIDTH+1){1'b0}}, mag_f(bus.mult2, bus.signed_mode)};
         mcand_r <= mag_f(bus.mult1, bus.signed_mode);
         neg_r   <= bus.signed_mode & (bus.mult1[WIDTH-1] ^ bus.mult2[WIDTH-1]);
         cnt_r   <= {CNT_W{1'b0}};
`ifdef MULT_EARLY_EXIT_EN
         mrem_r  <= mag_f(bus.mult2, bus.signed_mode);
`endif
      end else if (step_s) begin
         comb_r  <= comb_step_s;
         cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MULT_EARLY_EXIT_EN
         mrem_r  <= mrem_r >> 1;
`endif
      end
   end

   // Registered handshake outputs and product hold register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         produto_r <= {(2*WIDTH){1'b0}};
      end else begin
         busy_r <= (state_nxt_s != ST_IDLE);
         done_r <= finish_s;
         if (finish_s) begin
            produto_r <= result_s;
         end
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.produto = produto_r;
endmodule

// File: tb/tb_mult_seq_param.sv
// tb_mult_seq_param: directed and random checks of mult_seq_param against
// an arithmetic reference (integer multiply, bit-length latency).
module tb_mult_seq_param;
   localparam int W = 16;
`ifdef MULT_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [2*W-1:0] last_prod;

   mult_seq_param_if #(.WIDTH(W)) bus ();

   mult_seq_param #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic sm);
      longint sa;
      longint sb;
      longint p;
      if (sm) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      p = sa * sb;
      return p[2*W-1:0];
   endfunction

   function automatic int lat_f(input logic [W-1:0] b, input logic sm);
      longint m;
      int     n;
      m = sm ? longint'($signed(b)) : longint'(b);
      if (m < 0) m = -m;
      n = 1;
      for (int i = 0; i <= W; i++) if (m[i]) n = i + 1;
      return EARLY ? n + 1 : W + 1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input string tag);
      @(negedge clk);
      bus.mult1 = a;
      bus.mult2 = b;
      bus.signed_mode = sm;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk({tag, " busy"}, 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_done(input int exp_lat, input logic [2*W-1:0] exp_p,
                            input string tag);
      int got;
      got = -1;
      for (int c = 1; c <= W + 8; c++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            got = c;
            break;
         end
      end
      chk({tag, " latency"}, 64'(got), 64'(exp_lat));
      chk({tag, " produto"}, 64'(bus.produto), 64'(exp_p));
      chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
      last_prod = exp_p;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic [2*W-1:0] exp_p, input int exp_lat,
                         input string tag);
      launch(a, b, sm, tag);
      wait_done(exp_lat, exp_p, tag);
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sm;
      int           seen;
      total = 0;
      bad   = 0;
      last_prod = '0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.signed_mode = 1'b0;
      bus.mult1 = '0;
      bus.mult2 = '0;

      // reset state
      #12;
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset produto", 64'(bus.produto), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed products
      run_op(16'h0003, 16'h0005, 1'b0, 32'h0000000F, lat_f(16'h0005, 1'b0), "u 3*5");
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, lat_f(16'hFFFF, 1'b0), "u ffff*ffff");
      run_op(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, lat_f(16'h0005, 1'b1), "s -3*5");
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, lat_f(16'hFFFF, 1'b1), "s -1*-1");
      run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, lat_f(16'h8000, 1'b1), "s min*min");
      run_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, lat_f(16'h0001, 1'b1), "s min*1");
      run_op(16'h1234, 16'h0000, 1'b1, 32'h00000000, lat_f(16'h0000, 1'b1), "s x*0");

      // random operands against the arithmetic model
      for (int i = 0; i < 16; i++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         sm = 1'($urandom_range(0, 1));
         run_op(a, b, sm, ref_prod(a, b, sm), lat_f(b, sm), "random");
      end

      // start while busy with operands changed mid-run
      launch(16'h0101, 16'h1234, 1'b0, "busy start");
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mult1 = 16'hFFFF;
      bus.mult2 = 16'hFFFF;
      bus.signed_mode = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat_f(16'h1234, 1'b0) - 4, ref_prod(16'h0101, 16'h1234, 1'b0), "busy start");

      // back-to-back: start held during the done cycle
      launch(16'h0007, 16'h0009, 1'b0, "b2b first");
      wait_done(lat_f(16'h0009, 1'b0), 32'h0000003F, "b2b first");
      bus.mult1 = 16'hFFF0;
      bus.mult2 = 16'h0011;
      bus.signed_mode = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("b2b second busy", 64'(bus.busy), 64'd1);
      wait_done(lat_f(16'h0011, 1'b1), 32'hFFFFFEF0, "b2b second");

      // abort five cycles into RUN
      launch(16'h0033, 16'hF00F, 1'b0, "abort run");
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      chk("abort busy", 64'(bus.busy), 64'd0);
      chk("abort done", 64'(bus.done), 64'd0);
      seen = 0;
      repeat (W + 3) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) seen++;
      end
      chk("abort no done", 64'(seen), 64'd0);
      chk("abort produto held", 64'(bus.produto), 64'(last_prod));

      // abort together with start in IDLE
      @(negedge clk);
      bus.mult1 = 16'h0002;
      bus.mult2 = 16'h0002;
      bus.signed_mode = 1'b0;
      bus.abort = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk("abort+start busy", 64'(bus.busy), 64'd0);
      seen = 0;
      repeat (W + 3) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      chk("abort+start idle", 64'(seen), 64'd0);

      // asynchronous reset mid-RUN
      launch(16'h00AA, 16'h5555, 1'b0, "async rst");
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst busy", 64'(bus.busy), 64'd0);
      chk("async rst done", 64'(bus.done), 64'd0);
      chk("async rst produto", 64'(bus.produto), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'h0102, 16'h0304, 1'b0, ref_prod(16'h0102, 16'h0304, 1'b0),
             lat_f(16'h0304, 1'b0), "after rst");

`ifdef MULT_EARLY_EXIT_EN
      run_op(16'h1234, 16'h0001, 1'b0, 32'h00001234, 2, "ee mult2=1");
      run_op(16'h1234, 16'h0000, 1'b0, 32'h00000000, 2, "ee mult2=0");
      run_op(16'h0002, 16'h00FF, 1'b0, 32'h000001FE, 9, "ee 00ff");
      run_op(16'h0003, 16'h8000, 1'b0, 32'h00018000, 17, "ee 8000");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
